// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: classifies the RV instruction format and emits a
// sign-extended XLEN-bit immediate through a 2-entry skid buffer. Optional IMMGEN_CSR_EN adds the CSR uimm format.
module imm_gen_stage #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_flush,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [31:0]     io_in_instruction,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_imm,
    output logic [2:0]      io_out_fmt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam bit IS_RV64 = (XLEN == 64);

    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [63:0]     dec_imm64;
    logic [XLEN-1:0] dec_imm;

    logic            out_valid;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;

    logic in_fire;
    logic out_fire;

    always_comb begin
        dec_fmt = FMT_ILL;
        case (io_in_instruction[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
            7'b0011011: dec_fmt = IS_RV64 ? FMT_I : FMT_ILL;
            7'b1110011: begin
                dec_fmt = FMT_I;
`ifdef IMMGEN_CSR_EN
                if (io_in_instruction[14] && (io_in_instruction[13:12] != 2'b00))
                    dec_fmt = FMT_Z;
`endif
            end
            7'b0100011: dec_fmt = FMT_S;
            7'b1100011: dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111: dec_fmt = FMT_J;
            7'b0110011: dec_fmt = FMT_R;
            7'b0111011: dec_fmt = IS_RV64 ? FMT_R : FMT_ILL;
            default: dec_fmt = FMT_ILL;
        endcase
    end

    // Every immediate fits a sign-extended 32-bit value; widen once afterwards.
    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{io_in_instruction[31]}}, io_in_instruction[31:20]};
            FMT_S: dec_imm32 = {{20{io_in_instruction[31]}}, io_in_instruction[31:25],
                                io_in_instruction[11:7]};
            FMT_B: dec_imm32 = {{19{io_in_instruction[31]}}, io_in_instruction[31],
                                io_in_instruction[7], io_in_instruction[30:25],
                                io_in_instruction[11:8], 1'b0};
            FMT_U: dec_imm32 = {io_in_instruction[31:12], 12'd0};
            FMT_J: dec_imm32 = {{11{io_in_instruction[31]}}, io_in_instruction[31],
                                io_in_instruction[19:12], io_in_instruction[20],
                                io_in_instruction[30:21], 1'b0};
            FMT_Z: dec_imm32 = {27'd0, io_in_instruction[19:15]};
            default: dec_imm32 = 32'd0;
        endcase
        dec_imm64 = {{32{dec_imm32[31]}}, dec_imm32};
        dec_imm   = dec_imm64[XLEN-1:0];
    end

    assign io_in_ready  = !skid_valid;
    assign in_fire      = io_in_valid && io_in_ready;
    assign out_fire     = out_valid && io_out_ready;
    assign io_out_valid = out_valid;
    assign io_out_imm   = out_imm;
    assign io_out_fmt   = out_fmt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= 3'd0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= 3'd0;
        end else if (io_flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || (out_fire && !skid_valid)) begin
            out_valid <= in_fire;
            if (in_fire) begin
                out_imm <= dec_imm;
                out_fmt <= dec_fmt;
            end
        end else if (out_fire) begin
            // Skid drains into out; an input that edge refills skid.
            out_valid  <= 1'b1;
            out_imm    <= skid_imm;
            out_fmt    <= skid_fmt;
            skid_valid <= in_fire;
            if (in_fire) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: XLEN=64 and XLEN=32 instances share stimulus; decode table plus
// handshake, back-pressure, flush and reset sequences. Expectations follow IMMGEN_CSR_EN.
module tb_imm_gen_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_flush;
    logic        io_in_valid;
    logic [31:0] io_in_instruction;
    logic        io_out_ready;

    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;

    int checks = 0;
    int errors = 0;
    bit sb_en  = 1'b0;

    logic [66:0] exp_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
    } vec_t;

    vec_t vecs[13];

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_in_valid(io_in_valid), .io_in_ready(in_ready64),
        .io_in_instruction(io_in_instruction),
        .io_out_valid(out_valid64), .io_out_ready(io_out_ready),
        .io_out_imm(out_imm64), .io_out_fmt(out_fmt64)
    );

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_in_valid(io_in_valid), .io_in_ready(in_ready32),
        .io_in_instruction(io_in_instruction),
        .io_out_valid(out_valid32), .io_out_ready(io_out_ready),
        .io_out_imm(out_imm32), .io_out_fmt(out_fmt32)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input bit enq, input logic [2:0] fmt,
                        input logic [63:0] imm);
        io_in_valid       = 1'b1;
        io_in_instruction = inst;
        if (enq) exp_q.push_back({fmt, imm});
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: an output seen at the negedge with ready high fires on the next edge.
    always @(negedge clock) begin
        if (sb_en && out_valid64 && io_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got fmt %0d imm 0x%0h expected none",
                         out_fmt64, out_imm64);
            end else begin
                logic [66:0] e;
                e = exp_q.pop_front();
                check("sb_fmt", {61'd0, out_fmt64}, {61'd0, e[66:64]});
                check("sb_imm", out_imm64, e[63:0]);
            end
        end
    end

    initial begin
`ifdef IMMGEN_CSR_EN
        vecs[4]  = '{32'h3002D073, 3'd6, 64'd5, 3'd6, 32'd5};
`else
        vecs[4]  = '{32'h3002D073, 3'd1, 64'h300, 3'd1, 32'h300};
`endif
        vecs[0]  = '{32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF};
        vecs[1]  = '{32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 32'hFFFFFFFC};
        vecs[2]  = '{32'hFE000CE3, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 32'hFFFFFFF8};
        vecs[3]  = '{32'h123450B7, 3'd4, 64'h0000000012345000, 3'd4, 32'h12345000};
        vecs[5]  = '{32'h0000007F, 3'd7, 64'd0, 3'd7, 32'd0};
        vecs[6]  = '{32'h0000003B, 3'd0, 64'd0, 3'd7, 32'd0};
        vecs[7]  = '{32'hFFF0001B, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd7, 32'd0};
        vecs[8]  = '{32'h800000EF, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5, 32'hFFF00000};
        vecs[9]  = '{32'h00000033, 3'd0, 64'd0, 3'd0, 32'd0};
        vecs[10] = '{32'h80000017, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 32'h80000000};
        vecs[11] = '{32'h7FF02083, 3'd1, 64'h7FF, 3'd1, 32'h7FF};
        vecs[12] = '{32'h00008067, 3'd1, 64'd0, 3'd1, 32'd0};

        reset             = 1'b1;
        io_flush          = 1'b0;
        io_in_valid       = 1'b0;
        io_in_instruction = 32'd0;
        io_out_ready      = 1'b1;
        #2;
        check("reset_out_valid", {63'd0, out_valid64}, 64'd0);
        check("reset_out_imm", out_imm64, 64'd0);
        check("reset_out_fmt", {61'd0, out_fmt64}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready64}, 64'd1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("post_reset_in_ready", {63'd0, in_ready64}, 64'd1);

        // Decode table: back-to-back pushes, each checked one edge after acceptance.
        for (int i = 0; i < 13; i++) begin
            push(vecs[i].inst, 1'b0, 3'd0, 64'd0);
            check($sformatf("v%0d_valid64", i), {63'd0, out_valid64}, 64'd1);
            check($sformatf("v%0d_fmt64", i), {61'd0, out_fmt64}, {61'd0, vecs[i].fmt64});
            check($sformatf("v%0d_imm64", i), out_imm64, vecs[i].imm64);
            check($sformatf("v%0d_valid32", i), {63'd0, out_valid32}, 64'd1);
            check($sformatf("v%0d_fmt32", i), {61'd0, out_fmt32}, {61'd0, vecs[i].fmt32});
            check($sformatf("v%0d_imm32", i), {32'd0, out_imm32}, {32'd0, vecs[i].imm32});
        end
        @(posedge clock);
        #1;
        check("table_drained", {63'd0, out_valid64}, 64'd0);

        // Back-to-back through the scoreboard.
        sb_en = 1'b1;
        push(32'hFE112E23, 1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFC);
        push(32'hFE000CE3, 1'b1, 3'd3, 64'hFFFFFFFFFFFFFFF8);
        push(32'h123450B7, 1'b1, 3'd4, 64'h0000000012345000);
        wait_drain();

        // Back-pressure: two entries fill the buffer, a third is held off.
        io_out_ready = 1'b0;
        push(32'hFFF00093, 1'b1, 3'd1, 64'hFFFFFFFFFFFFFFFF);
        check("bp_ready_after_one", {63'd0, in_ready64}, 64'd1);
        push(32'h800000EF, 1'b1, 3'd5, 64'hFFFFFFFFFFF00000);
        check("bp_ready_after_two", {63'd0, in_ready64}, 64'd0);
        io_in_valid       = 1'b1;
        io_in_instruction = 32'h00000033;
        @(posedge clock);
        #1;
        check("bp_third_held_ready", {63'd0, in_ready64}, 64'd0);
        check("bp_stable_fmt", {61'd0, out_fmt64}, 64'd1);
        check("bp_stable_imm", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_ready_after_release", {63'd0, in_ready64}, 64'd1);
        wait_drain();

        // Flush with a concurrent input: nothing may emerge afterwards.
        io_out_ready = 1'b0;
        push(32'hFE112E23, 1'b0, 3'd0, 64'd0);
        push(32'hFE000CE3, 1'b0, 3'd0, 64'd0);
        io_flush          = 1'b1;
        io_in_valid       = 1'b1;
        io_in_instruction = 32'h123450B7;
        @(posedge clock);
        #1;
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        check("flush_out_valid", {63'd0, out_valid64}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready64}, 64'd1);
        io_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("flush_nothing_after", {63'd0, out_valid64}, 64'd0);

        // Asynchronous reset mid-cycle with an entry held.
        io_out_ready = 1'b0;
        push(32'hFFF00093, 1'b0, 3'd0, 64'd0);
        check("pre_reset_valid", {63'd0, out_valid64}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_valid", {63'd0, out_valid64}, 64'd0);
        check("async_reset_imm", out_imm64, 64'd0);
        check("async_reset_ready", {63'd0, in_ready64}, 64'd1);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        io_out_ready = 1'b1;
        push(32'h123450B7, 1'b1, 3'd4, 64'h0000000012345000);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
